// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: a 4-word register window in front of an
// 8-entry byte FIFO. Read data is registered so it lines up with the RAM's read data.
module uart_tx_mmio #(
    parameter logic [29:0] BASE_ADDR   = 30'h3FFFFFF0,
    parameter int          DEPTH       = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] ram_addr,
    input  logic [31:0] ram_wdata,
    input  logic        ram_re,
    input  logic        ram_we,
    output logic        hit,
    output logic        rsel,
    output logic [31:0] rdata,
    output logic        tx,
    output logic [1:0]  fsm_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Internal handshake: the CPU side pushes when push_req is high and the FIFO
    // accepts only when not full; the transmitter pops only when the FIFO is not
    // empty. Both take effect on the same clock edge that samples them.
    logic [1:0]    off;
    logic          wr_hit;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          empty;
    logic          busy;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   div_q;

    state_t        state, state_d;
    logic [15:0]   cnt, cnt_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [7:0]    shift, shift_d;
    logic          tx_d;
    logic [31:0]   reg_val;
    logic [31:0]   status;
    logic          unused_bits;

    assign off      = ram_addr[1:0];
    assign hit      = (ram_addr[29:2] == BASE_ADDR[29:2]);
    assign wr_hit   = ram_we & hit;
    assign push_req = wr_hit && (off == 2'd0);
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = push_req & ~full;
    assign busy     = (state != S_IDLE);
    assign fsm_state = state;
    assign unused_bits = &{1'b0, ram_wdata[31:16]};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ram_wdata[7:0];
        end
    end

    // Fullness is judged on pre-edge state, so a push into a full FIFO is
    // dropped even when the transmitter frees a slot on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (wr_hit && (off == 2'd1) && ram_wdata[3]) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= DEFAULT_DIV;
        end else if (wr_hit && (off == 2'd2)) begin
            div_q <= (ram_wdata[15:0] == 16'd0) ? 16'd1 : ram_wdata[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            bit_idx <= bit_idx_d;
            shift   <= shift_d;
            tx      <= tx_d;
        end
    end

    // cnt holds the cycles left in the current bit; the divisor is sampled only
    // when a new bit period is loaded.
    always_comb begin
        state_d   = state;
        cnt_d     = cnt;
        bit_idx_d = bit_idx;
        shift_d   = shift;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    cnt_d   = div_q - 16'd1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt == 16'd0) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = div_q - 16'd1;
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == 16'd0) begin
                    cnt_d = div_q - 16'd1;
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        shift_d   = {1'b0, shift[7:1]};
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            S_STOP: begin
                if (cnt == 16'd0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = mem[rd_ptr];
                        cnt_d   = div_q - 16'd1;
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is registered from the next state so the line changes on the same edge
    // as the state it belongs to.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign status = 32'({count, overflow, busy, empty, full});

    always_comb begin
        reg_val = 32'd0;
        case (off)
            2'd1:    reg_val = status;
            2'd2:    reg_val = {16'd0, div_q};
            default: reg_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'd0;
            rsel  <= 1'b0;
        end else begin
            rdata <= (ram_re && hit) ? reg_val : 32'd0;
            rsel  <= ram_re & hit;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a register-access vector table followed by
// hand-written frame sequences (single frame, back-to-back, baud change, reset).
module tb_uart_tx_mmio;

    localparam logic [29:0] BASE = 30'h3FFFFFF0;

    logic        clk;
    logic        reset;
    logic [29:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_re;
    logic        ram_we;
    logic        hit;
    logic        rsel;
    logic [31:0] rdata;
    logic        tx;
    logic [1:0]  fsm_state;

    uart_tx_mmio #(
        .BASE_ADDR  (BASE),
        .DEPTH      (8),
        .DEFAULT_DIV(16'd104)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_re   (ram_re),
        .ram_we   (ram_we),
        .hit      (hit),
        .rsel     (rsel),
        .rdata    (rdata),
        .tx       (tx),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // ---------------- scoreboard counters ----------------
    int vec_cnt  = 0;
    int miss_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic cpu_write(input logic [29:0] a, input logic [31:0] d);
        ram_addr  = a;
        ram_wdata = d;
        ram_we    = 1'b1;
        @(negedge clk);
        ram_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [29:0] a, output logic [31:0] d, output logic s);
        ram_addr = a;
        ram_re   = 1'b1;
        @(negedge clk);
        d        = rdata;
        s        = rsel;
        ram_re   = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [29:0] addr;
        logic        we;
        logic        re;
        logic [31:0] wdata;
        logic        exp_hit;
        logic        exp_rsel;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[16];

    logic [31:0] rd;
    logic        rs;
    logic [7:0]  b_data[10];
    logic        b_got[90];
    logic        b_exp[$];
    logic        b_fell;
    logic        c_got[64];
    logic        c_exp[64];
    int          errs;
    int          n;

    initial begin
        tbl[0]  = '{BASE + 30'd1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0000_0002};
        tbl[1]  = '{BASE + 30'd2, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'd104};
        tbl[2]  = '{BASE,         1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[3]  = '{BASE + 30'd3, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[4]  = '{BASE + 30'd4, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[5]  = '{BASE + 30'd3, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{BASE + 30'd4, 1'b1, 1'b0, 32'h0000_00AB, 1'b0, 1'b0, 32'h0};
        tbl[7]  = '{BASE + 30'd6, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
        tbl[8]  = '{BASE + 30'd1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0000_0002};
        tbl[9]  = '{BASE + 30'd2, 1'b1, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[10] = '{BASE + 30'd2, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'd1};
        tbl[11] = '{BASE + 30'd2, 1'b1, 1'b0, 32'hFFFF_0007, 1'b1, 1'b0, 32'h0};
        tbl[12] = '{BASE + 30'd2, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'd7};
        tbl[13] = '{BASE + 30'd2, 1'b1, 1'b1, 32'd4,         1'b1, 1'b1, 32'd7};
        tbl[14] = '{BASE + 30'd2, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'd4};
        tbl[15] = '{BASE + 30'd1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b1, 32'h0000_0002};

        b_data = '{8'hA3, 8'h5C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h33, 8'hCC, 8'h96, 8'hE7};

        // ---------------- reset ----------------
        reset     = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_re    = 1'b0;
        ram_we    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_rsel", 32'(rsel), 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_state", 32'(fsm_state), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // ---------------- register vector table ----------------
        for (int i = 0; i < 16; i++) begin
            ram_addr  = tbl[i].addr;
            ram_we    = tbl[i].we;
            ram_re    = tbl[i].re;
            ram_wdata = tbl[i].wdata;
            #1;
            check($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].exp_hit));
            @(negedge clk);
            check($sformatf("vec%0d_rsel", i), 32'(rsel), 32'(tbl[i].exp_rsel));
            check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
        check("table_tx_idle", 32'(tx), 32'd1);

        // ---------------- A: single frame 0x55 at div 4 ----------------
        cpu_write(BASE, 32'h55);
        check("a_tx_before_pop", 32'(tx), 32'd1);
        @(posedge clk);
        #1;
        check("a_fall", 32'(tx), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            logic [9:0] exp_a;
            exp_a = {1'b1, 8'h55, 1'b0};
            check($sformatf("a_bit%0d", k), 32'(tx), 32'(exp_a[k]));
            if (k < 9) repeat (4) @(negedge clk);
        end
        @(negedge clk);
        check("a_busy_at_39", 32'(fsm_state), 32'd3);
        @(negedge clk);
        check("a_idle_at_40", 32'(fsm_state), 32'd0);
        cpu_read(BASE + 30'd1, rd, rs);
        check("a_status_after", rd, 32'h2);

        // ---------------- B: nine back-to-back frames at div 2 ----------------
        cpu_write(BASE + 30'd2, 32'd2);
        b_fell = 1'b0;
        fork
            begin
                n = 0;
                while (tx && n < 100) begin
                    @(negedge clk);
                    n++;
                end
                b_fell = ~tx;
                for (int k = 0; k < 90; k++) begin
                    b_got[k] = tx;
                    repeat (2) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 9; i++) cpu_write(BASE, 32'(b_data[i]));
                cpu_read(BASE + 30'd1, rd, rs);
                check("b_status_full", rd, 32'h85);
                cpu_write(BASE, 32'(b_data[9]));
                cpu_read(BASE + 30'd1, rd, rs);
                check("b_status_ovf", rd, 32'h8D);
            end
        join
        check("b_fall_seen", 32'(b_fell), 32'd1);
        for (int f = 0; f < 9; f++) begin
            b_exp.push_back(1'b0);
            for (int j = 0; j < 8; j++) b_exp.push_back(b_data[f][j]);
            b_exp.push_back(1'b1);
        end
        errs = 0;
        for (int k = 0; k < 90; k++) if (b_got[k] !== b_exp[k]) errs++;
        check("b_stream_bit_errors", 32'(errs), 32'd0);
        check("b_idle_after_9", 32'(fsm_state), 32'd0);
        check("b_tx_idle", 32'(tx), 32'd1);
        cpu_read(BASE + 30'd1, rd, rs);
        check("b_status_empty_ovf", rd, 32'h0A);
        cpu_write(BASE + 30'd1, 32'h8);
        cpu_read(BASE + 30'd1, rd, rs);
        check("b_ovf_cleared", rd, 32'h2);

        // ---------------- C: baud change 4 -> 8 during data bit 3 ----------------
        cpu_write(BASE + 30'd2, 32'd4);
        cpu_write(BASE, 32'h55);
        n = 0;
        while (tx && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("c_fall_seen", 32'(tx), 32'd0);
        for (int c = 0; c < 64; c++) begin
            c_got[c] = tx;
            if (c == 16) begin
                ram_addr  = BASE + 30'd2;
                ram_wdata = 32'd8;
                ram_we    = 1'b1;
            end
            if (c == 17) ram_we = 1'b0;
            @(negedge clk);
        end
        begin
            int dur[10];
            logic [9:0] lvl;
            int pos;
            dur = '{4, 4, 4, 4, 4, 8, 8, 8, 8, 8};
            lvl = {1'b1, 8'h55, 1'b0};
            pos = 0;
            for (int c = 0; c < 64; c++) c_exp[c] = 1'b1;
            for (int s = 0; s < 10; s++) begin
                for (int d = 0; d < dur[s]; d++) begin
                    c_exp[pos] = lvl[s];
                    pos++;
                end
            end
        end
        errs = 0;
        for (int c = 0; c < 64; c++) if (c_got[c] !== c_exp[c]) errs++;
        check("c_wave_cycle_errors", 32'(errs), 32'd0);
        check("c_idle_after", 32'(fsm_state), 32'd0);

        // ---------------- D: reset during data bit 2 with 3 bytes queued ----------------
        cpu_write(BASE + 30'd2, 32'd4);
        cpu_write(BASE, 32'h01);
        cpu_write(BASE, 32'h02);
        cpu_write(BASE, 32'h03);
        cpu_write(BASE, 32'h04);
        repeat (11) @(negedge clk);
        check("d_pre_state_data", 32'(fsm_state), 32'd2);
        check("d_pre_tx_bit2", 32'(tx), 32'd0);
        reset = 1'b0;
        #1;
        check("d_reset_tx_high", 32'(tx), 32'd1);
        check("d_reset_state", 32'(fsm_state), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        cpu_read(BASE + 30'd1, rd, rs);
        check("d_status_after", rd, 32'h2);
        check("d_rsel_after", 32'(rs), 32'd1);
        cpu_read(BASE + 30'd2, rd, rs);
        check("d_div_default", rd, 32'd104);
        errs = 0;
        for (int c = 0; c < 60; c++) begin
            if (tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check("d_no_frames_low_cycles", 32'(errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
